// File: rtl/operand_entry.sv
// -----------------------------------------------------------------------------
// operand_entry
//
// Operand entry controller for the signed 8-bit adder. Debounced button levels
// are turned into single-cycle press events, which a small FSM uses to edit
// two signed operands (A, then B). When B is confirmed, the sign-extended
// 9-bit sum and an overflow flag are registered for the display/adder logic.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   btn[3:0]   in   debounced button levels: [0] inc, [1] dec, [2] negate,
//                   [3] next
//   op_a[7:0]  out  operand A, two's complement
//   op_b[7:0]  out  operand B, two's complement
//   sum[8:0]   out  registered {a[7],a} + {b[7],b}
//   ovf        out  true sum outside -128..127
//   sum_valid  out  sum/ovf reflect the current operands
//   state[1:0] out  FSM state (0 = S_A, 1 = S_B, 2 = S_RES)
//
// Build option
//   OPERAND_ENTRY_AUTO_REPEAT_EN  when defined, a held inc/dec button
//   auto-repeats: the first synthetic step fires REPEAT_DELAY cycles after the
//   press edge, then one step every REPEAT_RATE cycles. When undefined, a held
//   button yields exactly one step and the REPEAT parameters are unused.
//   Both parameters must be at least 1 when the option is enabled.
//
// FSM states
//   state | meaning
//   ------+---------------------------------------------------------------
//   S_A   | editing operand A; next moves to S_B
//   S_B   | editing operand B; next registers sum/ovf and moves to S_RES
//   S_RES | result shown; edits ignored; next returns to S_A
//   S_BAD | unreachable encoding; recovers to S_A and clears sum_valid
// -----------------------------------------------------------------------------
module operand_entry #(
  parameter logic [23:0] REPEAT_DELAY = 24'd5_000_000,
  parameter logic [23:0] REPEAT_RATE  = 24'd1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic [8:0] sum,
  output logic       ovf,
  output logic       sum_valid,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_RES = 2'd2,
    S_BAD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  btn_q, btn_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic [8:0]  sum_q, sum_d;
  logic        ovf_q, ovf_d;
  logic        sum_valid_q, sum_valid_d;

  logic [3:0]  press;
  logic        rpt_step;
  logic        do_inc;
  logic        do_dec;
  logic [7:0]  edit_cur;
  logic [7:0]  edit_new;
  logic [8:0]  sum_calc;

  // btn_q resets to all ones so a button held through reset is not a press.
  assign press = btn & ~btn_q;

`ifdef OPERAND_ENTRY_AUTO_REPEAT_EN
  // Down-counter: 0 = idle, loaded with REPEAT_DELAY on the press edge,
  // terminal count at 1 emits a synthetic step and reloads REPEAT_RATE.
  logic [23:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_hold;

  assign rpt_hold = ((btn == 4'b0001) || (btn == 4'b0010)) &&
                    ((state_q == S_A) || (state_q == S_B));

  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_step  = 1'b0;
    if (!rpt_hold) begin
      rpt_cnt_d = 24'd0;
    end else if (|press[1:0]) begin
      rpt_cnt_d = REPEAT_DELAY;
    end else if (rpt_cnt_q == 24'd1) begin
      rpt_cnt_d = REPEAT_RATE;
      rpt_step  = 1'b1;
    end else if (rpt_cnt_q != 24'd0) begin
      rpt_cnt_d = rpt_cnt_q - 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_q <= 24'd0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  logic unused_repeat_params;
  assign unused_repeat_params = ^{REPEAT_DELAY, REPEAT_RATE};
  assign rpt_step = 1'b0;
`endif

  // While a single inc/dec is held, btn itself tells which way to step.
  assign do_inc = press[0] | (rpt_step & btn[0]);
  assign do_dec = press[1] | (rpt_step & btn[1]);

  assign sum_calc = {op_a_q[7], op_a_q} + {op_b_q[7], op_b_q};

  // Operand under edit; only meaningful in S_A/S_B.
  assign edit_cur = (state_q == S_B) ? op_b_q : op_a_q;

  // Priority next > negate > inc > dec; lower-priority presses are dropped.
  always_comb begin
    edit_new = edit_cur;
    if (press[3]) begin
      edit_new = edit_cur;
    end else if (press[2]) begin
      edit_new = 8'd0 - edit_cur;
    end else if (do_inc) begin
      edit_new = edit_cur + 8'd1;
    end else if (do_dec) begin
      edit_new = edit_cur - 8'd1;
    end
  end

  always_comb begin
    btn_d       = btn;
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    sum_valid_d = sum_valid_q;

    case (state_q)
      S_A: begin
        op_a_d = edit_new;
        if (press[3]) begin
          state_d = S_B;
        end
      end
      S_B: begin
        op_b_d = edit_new;
        if (press[3]) begin
          state_d     = S_RES;
          sum_d       = sum_calc;
          ovf_d       = sum_calc[8] ^ sum_calc[7];
          sum_valid_d = 1'b1;
        end
      end
      S_RES: begin
        if (press[3]) begin
          state_d     = S_A;
          sum_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_A;
        sum_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q       <= 4'b1111;
      state_q     <= S_A;
      op_a_q      <= 8'd0;
      op_b_q      <= 8'd0;
      sum_q       <= 9'd0;
      ovf_q       <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      btn_q       <= btn_d;
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;
  assign sum_valid = sum_valid_q;
  assign state     = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// -----------------------------------------------------------------------------
// tb_operand_entry
//
// Directed bench for operand_entry. A behavioural model (integer operands,
// press history, hold length for auto-repeat) is compared against every DUT
// output on each falling edge; literal expectations pin key points.
// -----------------------------------------------------------------------------
module tb_operand_entry;

  localparam logic [23:0] T_DELAY = 24'd10;
  localparam logic [23:0] T_RATE  = 24'd4;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [8:0] sum;
  logic       ovf;
  logic       sum_valid;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  operand_entry #(
    .REPEAT_DELAY(T_DELAY),
    .REPEAT_RATE (T_RATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .op_a     (op_a),
    .op_b     (op_b),
    .sum      (sum),
    .ovf      (ovf),
    .sum_valid(sum_valid),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int w8(input int x);
    int y;
    y = x % 256;
    if (y > 127) y -= 256;
    else if (y < -128) y += 256;
    return y;
  endfunction

  // ---------------- behavioural model ----------------
  int         ma = 0, mb = 0, ms = 0, msum = 0, rlen = 0;
  bit         movf = 0, mvalid = 0, ract = 0;
  logic [3:0] prev = 4'hF;

  always @(posedge clk) begin : model
    logic [3:0] pr;
    bit single, syn, inc, dec;
    int s;
    if (rst) begin
      ma = 0; mb = 0; ms = 0; msum = 0; movf = 0; mvalid = 0;
      prev = 4'hF; ract = 0; rlen = 0;
    end else begin
      pr     = btn & ~prev;
      single = ((btn == 4'b0001) || (btn == 4'b0010)) && (ms != 2);
      syn    = 0;
`ifdef OPERAND_ENTRY_AUTO_REPEAT_EN
      if (pr[0] || pr[1]) begin
        ract = single;
        rlen = 0;
      end else if (single && ract) begin
        rlen++;
        if (rlen >= int'(T_DELAY) && ((rlen - int'(T_DELAY)) % int'(T_RATE)) == 0)
          syn = 1;
      end else begin
        ract = 0;
      end
`endif
      inc = pr[0] || (syn && btn[0]);
      dec = pr[1] || (syn && btn[1]);
      if (ms == 0 || ms == 1) begin
        if (pr[3]) begin
          if (ms == 0) ms = 1;
          else begin
            s      = ma + mb;
            msum   = s;
            movf   = (s > 127) || (s < -128);
            mvalid = 1;
            ms     = 2;
          end
        end else begin
          s = (ms == 0) ? ma : mb;
          if (pr[2])    s = w8(-s);
          else if (inc) s = w8(s + 1);
          else if (dec) s = w8(s - 1);
          if (ms == 0) ma = s; else mb = s;
        end
      end else if (ms == 2) begin
        if (pr[3]) begin
          ms     = 0;
          mvalid = 0;
        end
      end
      prev = btn;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("op_a",      int'($signed(op_a)), ma);
    chk("op_b",      int'($signed(op_b)), mb);
    chk("sum",       int'(sum),           msum & 32'h1FF);
    chk("ovf",       int'(ovf),           int'(movf));
    chk("sum_valid", int'(sum_valid),     int'(mvalid));
    chk("state",     int'(state),         ms);
  end

  task automatic step(input logic [3:0] b);
    btn = b;
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] b);
    step(b);
    step(4'b0000);
  endtask

  int exp_rep;

  initial begin
    rst = 1'b1;
    btn = 4'b0001;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) step(4'b0001);
    chk("rst_hold_op_a",  int'(op_a),  0);
    chk("rst_hold_state", int'(state), 0);
    step(4'b0000);

    // A = 100 via 99 incs and an inc+dec press (inc wins)
    repeat (99) press(4'b0001);
    press(4'b0011);
    chk("a_100", int'(op_a), 100);
    press(4'b1000);
    chk("state_b", int'(state), 1);
    repeat (50) press(4'b0001);
    chk("b_50", int'(op_b), 50);
    press(4'b1000);
    chk("res_state", int'(state),     2);
    chk("res_sum",   int'(sum),       150);
    chk("res_ovf",   int'(ovf),       1);
    chk("res_valid", int'(sum_valid), 1);
    chk("model_sum", msum,            150);

    // edits ignored in S_RES
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    chk("sres_a",   int'(op_a), 100);
    chk("sres_b",   int'(op_b), 50);
    chk("sres_sum", int'(sum),  150);
    press(4'b1000);
    chk("back_state", int'(state),     0);
    chk("back_valid", int'(sum_valid), 0);
    chk("back_a",     int'(op_a),      100);
    chk("back_b",     int'(op_b),      50);

    // wrap around in A
    repeat (27) press(4'b0001);
    chk("a_127", int'(op_a), 127);
    press(4'b0001);
    chk("wrap_up", int'(op_a), 8'h80);
    press(4'b0010);
    chk("wrap_dn", int'(op_a), 8'h7F);
    press(4'b0001);
    press(4'b0100);
    chk("neg_min", int'(op_a), 8'h80);
    chk("model_neg_min", ma, -128);

    // next beats negate and inc
    press(4'b1101);
    chk("prio_state", int'(state), 1);
    chk("prio_a",     int'(op_a),  8'h80);
    chk("prio_b",     int'(op_b),  50);

    // B = -1 via negate then 49 incs
    press(4'b0100);
    chk("neg_b", int'(op_b), 8'hCE);
    repeat (49) press(4'b0001);
    chk("b_m1", int'(op_b), 8'hFF);
    press(4'b1000);
    chk("neg_sum",   int'(sum),       9'h17F);
    chk("neg_ovf",   int'(ovf),       1);
    chk("neg_valid", int'(sum_valid), 1);
    press(4'b1000);

    // reset, then hold inc for 22 cycles
    rst = 1'b1;
    btn = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(4'b0000);
    chk("rst2_a",     int'(op_a),      0);
    chk("rst2_b",     int'(op_b),      0);
    chk("rst2_sum",   int'(sum),       0);
    chk("rst2_valid", int'(sum_valid), 0);
    repeat (22) step(4'b0001);
    step(4'b0000);
`ifdef OPERAND_ENTRY_AUTO_REPEAT_EN
    exp_rep = 4;
`else
    exp_rep = 1;
`endif
    chk("hold_22", int'(op_a), exp_rep);
    step(4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
